// File: rtl/wbcav_multi.sv
// wbcav_multi: multi-channel windowed bracketed CAV detector with a sliding N_WIN window sum.
// Define WBCAV_LATCH_EN for sticky alarms that are cleared by i_accept.

module wbcav_multi #(
    parameter int CLK_DIV = 100000,
    parameter int N_CH = 3,
    parameter int DATA_W = 24,
    parameter int SAMPLES_PER_WIN = 1000,
    parameter int N_WIN = 16,
    parameter logic [DATA_W-1:0] WIN_THRESHOLD = 24'h006666,
    parameter int TS_W = 20,
    parameter logic [TS_W-1:0] TIMESCALE = 20'h00419,
    parameter logic [DATA_W+$clog2(SAMPLES_PER_WIN)+$clog2(N_WIN)+TS_W-1:0] CAV_THRESHOLD =
        58'h0001_0000000000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_CH*DATA_W-1:0]   i_data,
    input  logic                     i_accept,
    output logic                     o_win_done,
    output logic [N_CH*(DATA_W+$clog2(SAMPLES_PER_WIN)+$clog2(N_WIN)+TS_W)-1:0] o_cav,
    output logic [N_CH-1:0]          o_alarm_ch,
    output logic                     o_alarm
);

    localparam int ACC_W = DATA_W + $clog2(SAMPLES_PER_WIN);
    localparam int SUM_W = ACC_W + $clog2(N_WIN);
    localparam int CAV_W = SUM_W + TS_W;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = (SAMPLES_PER_WIN > 1) ? $clog2(SAMPLES_PER_WIN) : 1;
    localparam int PTR_W = $clog2(N_WIN);

    localparam logic [1:0] S_ACCUM  = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_MULT   = 2'd2;
    localparam logic [1:0] S_CMP    = 2'd3;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [CNT_W-1:0] smp_cnt;
    logic             closing;
    logic [1:0]       state;
    logic [PTR_W-1:0] ptr;

    logic [ACC_W-1:0]  acc     [N_CH];
    logic [N_CH-1:0]   valid;
    logic [SUM_W-1:0]  ring    [N_CH][N_WIN];
    logic [SUM_W-1:0]  sum     [N_CH];
    logic [CAV_W-1:0]  cav     [N_CH];

    logic [DATA_W-1:0] samp    [N_CH];
    logic [ACC_W-1:0]  acc_nxt [N_CH];
    logic [N_CH-1:0]   over;
    logic [SUM_W-1:0]  win_val [N_CH];
    logic [N_CH-1:0]   hit;
    logic [N_CH-1:0]   alarm_nxt;

    assign tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign closing = tick && (smp_cnt == CNT_W'(SAMPLES_PER_WIN - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt <= '0;
            smp_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                smp_cnt <= closing ? '0 : smp_cnt + 1'b1;
        end
    end

    // The closing sample is folded into the window value combinationally.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            samp[c]    = i_data[c*DATA_W +: DATA_W];
            acc_nxt[c] = acc[c] + ACC_W'(samp[c]);
            over[c]    = samp[c] > WIN_THRESHOLD;
            win_val[c] = (valid[c] || over[c]) ? SUM_W'(acc_nxt[c]) : '0;
            hit[c]     = cav[c] > CAV_THRESHOLD;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid <= '0;
            for (int c = 0; c < N_CH; c++) begin
                acc[c] <= '0;
                sum[c] <= '0;
                for (int k = 0; k < N_WIN; k++)
                    ring[c][k] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (tick) begin
                    acc[c]   <= closing ? '0 : acc_nxt[c];
                    valid[c] <= closing ? 1'b0 : (valid[c] | over[c]);
                end
                // The oldest entry is always part of sum, so the subtraction cannot underflow.
                if (closing) begin
                    ring[c][ptr] <= win_val[c];
                    sum[c]       <= sum[c] + win_val[c] - ring[c][ptr];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_ACCUM;
            ptr        <= '0;
            o_win_done <= 1'b0;
            o_cav      <= '0;
            for (int c = 0; c < N_CH; c++)
                cav[c] <= '0;
        end else begin
            case (state)
                S_ACCUM: begin
                    if (closing) begin
                        state <= S_UPDATE;
                        ptr   <= (ptr == PTR_W'(N_WIN - 1)) ? '0 : ptr + 1'b1;
                    end
                end
                S_UPDATE: begin
                    for (int c = 0; c < N_CH; c++)
                        cav[c] <= CAV_W'(sum[c]) * CAV_W'(TIMESCALE);
                    state <= S_MULT;
                end
                S_MULT: begin
                    for (int c = 0; c < N_CH; c++)
                        o_cav[c*CAV_W +: CAV_W] <= cav[c];
                    o_win_done <= 1'b1;
                    state      <= S_CMP;
                end
                S_CMP: begin
                    o_win_done <= 1'b0;
                    state      <= S_ACCUM;
                end
                default: state <= S_ACCUM;
            endcase
        end
    end

`ifdef WBCAV_LATCH_EN
    logic [N_CH-1:0] hit_q;

    // An acknowledge landing in the same CMP cycle as a fresh hit must not clear that hit.
    always_comb begin
        alarm_nxt = o_alarm_ch;
        if (i_accept)
            alarm_nxt = (state == S_CMP) ? (o_alarm_ch & hit_q) : '0;
        if (state == S_MULT)
            alarm_nxt = alarm_nxt | hit;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            hit_q <= '0;
        else if (state == S_MULT)
            hit_q <= hit;
    end
`else
    logic accept_unused;
    assign accept_unused = i_accept;

    always_comb begin
        alarm_nxt = (state == S_MULT) ? hit : o_alarm_ch;
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_alarm_ch <= '0;
            o_alarm    <= 1'b0;
        end else begin
            o_alarm_ch <= alarm_nxt;
            o_alarm    <= |alarm_nxt;
        end
    end

endmodule

// File: tb/tb_wbcav_multi.sv
// Scoreboard bench for wbcav_multi: two instances (window threshold 10 and 0) share the stimulus.
// A transaction-level model pushes expected CAV/alarms at each window close; the monitor pops on o_win_done.

module tb_wbcav_multi;

    localparam int N_CH = 3;
    localparam int DATA_W = 24;
    localparam int SPW = 4;
    localparam int N_WIN = 4;
    localparam int CLK_DIV = 8;
    localparam int TS_W = 20;
    localparam int CAV_W = 48;
    localparam longint unsigned TSCALE = 1;
    localparam longint unsigned CAV_THR = 100;
`ifdef WBCAV_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    typedef struct {
        logic [N_CH*CAV_W-1:0] cav;
        logic [N_CH-1:0]       alarm;
    } exp_t;

    logic                   i_clk = 1'b0;
    logic                   i_rst_n = 1'b0;
    logic                   i_accept = 1'b0;
    logic [N_CH*DATA_W-1:0] i_data = '0;

    logic                   done0, done1;
    logic [N_CH*CAV_W-1:0]  cav0, cav1;
    logic [N_CH-1:0]        alch0, alch1;
    logic                   al0, al1;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0, e1;
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;

    longint unsigned m_acc [2][N_CH];
    bit              m_valid [2][N_CH];
    longint unsigned m_win [2][N_CH][N_WIN];
    logic [N_CH-1:0] m_alarm [2];
    logic [N_CH-1:0] m_hit [2];
    int              m_cnt, m_slot;

    wbcav_multi #(
        .CLK_DIV(CLK_DIV), .N_CH(N_CH), .DATA_W(DATA_W), .SAMPLES_PER_WIN(SPW), .N_WIN(N_WIN),
        .WIN_THRESHOLD(24'd10), .TS_W(TS_W), .TIMESCALE(20'd1), .CAV_THRESHOLD(48'd100)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_accept(i_accept),
        .o_win_done(done0), .o_cav(cav0), .o_alarm_ch(alch0), .o_alarm(al0)
    );

    wbcav_multi #(
        .CLK_DIV(CLK_DIV), .N_CH(N_CH), .DATA_W(DATA_W), .SAMPLES_PER_WIN(SPW), .N_WIN(N_WIN),
        .WIN_THRESHOLD(24'd0), .TS_W(TS_W), .TIMESCALE(20'd1), .CAV_THRESHOLD(48'd100)
    ) dut_wrap (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_accept(i_accept),
        .o_win_done(done1), .o_cav(cav1), .o_alarm_ch(alch1), .o_alarm(al1)
    );

    always #5 i_clk = ~i_clk;

    // Bench-side cycle count since reset release; multiples of CLK_DIV are the sampling edges.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [191:0] act, input logic [191:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic longint unsigned thr(int i);
        return (i == 0) ? 64'd10 : 64'd0;
    endfunction

    function automatic logic [N_CH*DATA_W-1:0] pack(int a, int b, int c);
        return {DATA_W'(c), DATA_W'(b), DATA_W'(a)};
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 2; i++) begin
            m_alarm[i] = '0;
            m_hit[i]   = '0;
            for (int c = 0; c < N_CH; c++) begin
                m_acc[i][c]   = 0;
                m_valid[i][c] = 1'b0;
                for (int k = 0; k < N_WIN; k++) m_win[i][c][k] = 0;
            end
        end
        m_cnt  = 0;
        m_slot = 0;
    endfunction

    function automatic void modelSample(logic [N_CH*DATA_W-1:0] d);
        exp_t e;
        longint unsigned s, w, tot;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < N_CH; c++) begin
                s = 64'(d[c*DATA_W +: DATA_W]);
                m_acc[i][c] += s;
                if (s > thr(i)) m_valid[i][c] = 1'b1;
            end
        if (m_cnt == SPW - 1) begin
            for (int i = 0; i < 2; i++) begin
                e.cav = '0;
                for (int c = 0; c < N_CH; c++) begin
                    w = m_valid[i][c] ? m_acc[i][c] : 0;
                    m_win[i][c][m_slot] = w;
                    tot = 0;
                    for (int k = 0; k < N_WIN; k++) tot += m_win[i][c][k];
                    e.cav[c*CAV_W +: CAV_W] = CAV_W'(tot * TSCALE);
                    m_hit[i][c] = (tot * TSCALE) > CAV_THR;
                    m_acc[i][c] = 0;
                    m_valid[i][c] = 1'b0;
                end
                m_alarm[i] = LATCH ? (m_alarm[i] | m_hit[i]) : m_hit[i];
                e.alarm = m_alarm[i];
                if (i == 0) sb0.push_back(e);
                else        sb1.push_back(e);
            end
            m_slot = (m_slot + 1) % N_WIN;
            m_cnt  = 0;
        end else begin
            m_cnt++;
        end
    endfunction

    // Holds one sample until the DUT's sampling edge, then returns 1 time unit after it.
    task automatic applyStimulus(input logic [N_CH*DATA_W-1:0] d);
        i_data = d;
        for (int k = 0; k < CLK_DIV; k++) begin
            @(posedge i_clk);
            #1;
            if (cyc % CLK_DIV == 0) break;
        end
        modelSample(d);
    endtask

    task automatic applyWindow(input logic [N_CH*DATA_W-1:0] d);
        for (int k = 0; k < SPW; k++) applyStimulus(d);
    endtask

    task automatic applySpike(input logic [N_CH*DATA_W-1:0] d);
        applyStimulus(d);
        for (int k = 1; k < SPW; k++) applyStimulus('0);
    endtask

    task automatic checkReset();
        checkOutput("rst_done0", done0, 0);
        checkOutput("rst_cav0", cav0, 0);
        checkOutput("rst_alch0", alch0, 0);
        checkOutput("rst_al0", al0, 0);
        checkOutput("rst_done1", done1, 0);
        checkOutput("rst_cav1", cav1, 0);
        checkOutput("rst_alch1", alch1, 0);
        checkOutput("rst_al1", al1, 0);
    endtask

    task automatic doReset();
        repeat (4) @(posedge i_clk);
        checkOutput("drain0", sb0.size(), 0);
        checkOutput("drain1", sb1.size(), 0);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_data  = '0;
        modelReset();
        repeat (2) @(posedge i_clk);
        #1;
        checkReset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (prev0) checkOutput("done0_width", done0, 0);
            if (prev1) checkOutput("done1_width", done1, 0);
            if (done0) begin
                checkOutput("sb0_pending", sb0.size() != 0, 1);
                if (sb0.size() != 0) begin
                    e0 = sb0.pop_front();
                    checkOutput("cav0", cav0, e0.cav);
                    checkOutput("alarm_ch0", alch0, e0.alarm);
                    checkOutput("alarm0", al0, |e0.alarm);
                end
            end
            if (done1) begin
                checkOutput("sb1_pending", sb1.size() != 0, 1);
                if (sb1.size() != 0) begin
                    e1 = sb1.pop_front();
                    checkOutput("cav1", cav1, e1.cav);
                    checkOutput("alarm_ch1", alch1, e1.alarm);
                    checkOutput("alarm1", al1, |e1.alarm);
                end
            end
        end
        prev0 <= done0;
        prev1 <= done1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        repeat (3) @(posedge i_clk);
        #1;
        checkReset();
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Reset mid-window: the partial window must be discarded.
        applyStimulus(pack(50, 0, 0));
        applyStimulus(pack(50, 0, 0));
        doReset();
        for (int k = 0; k < SPW - 1; k++) applyStimulus(pack(50, 0, 0));
        applyStimulus(pack(50, 0, 0));
        @(posedge i_clk); #1;
        checkOutput("lat_t1_done", done0, 0);
        @(posedge i_clk); #1;
        checkOutput("lat_t3_done", done0, 1);
        @(posedge i_clk); #1;
        checkOutput("lat_t4_done", done0, 0);

        // Window-valid threshold boundary.
        doReset();
        applyWindow(pack(10, 10, 10));
        applyWindow(pack(11, 11, 11));

        // Single-channel hit followed by expiry.
        doReset();
        applyWindow(pack(0, 30, 0));
        for (int w = 0; w < N_WIN; w++) applyWindow('0);

        // Acknowledge away from CMP.
        applyStimulus('0);
        i_accept = 1'b1;
        @(posedge i_clk); #1;
        i_accept = 1'b0;
        for (int i = 0; i < 2; i++) if (LATCH) m_alarm[i] = '0;
        checkOutput("accept_clr0", alch0, m_alarm[0]);
        checkOutput("accept_clr1", alch1, m_alarm[1]);
        for (int k = 1; k < SPW; k++) applyStimulus('0);

        // Acknowledge coinciding with the CMP cycle of a new hit.
        applyWindow(pack(0, 30, 0));
        @(posedge i_clk);
        @(posedge i_clk); #1;
        i_accept = 1'b1;
        @(posedge i_clk); #1;
        i_accept = 1'b0;
        for (int i = 0; i < 2; i++) if (LATCH) m_alarm[i] = m_hit[i];
        checkOutput("accept_cmp0", alch0, m_alarm[0]);
        checkOutput("accept_cmp1", alch1, m_alarm[1]);

        // Ring wrap with one non-zero ch2 sample per window.
        doReset();
        for (int v = 10; v <= 60; v += 10) applySpike(pack(0, 0, v));

        repeat (6) @(posedge i_clk);
        checkOutput("final_drain0", sb0.size(), 0);
        checkOutput("final_drain1", sb1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wbcav_multi.md
# wbcav_multi

Parametrised multi-channel windowed bracketed cumulative absolute velocity (WBCAV) detector. It runs in the system clock domain and uses an internal sample-tick divider instead of a derived clock. It accumulates N_CH scaled acceleration magnitudes over fixed-length windows and keeps a sliding sum of the last N_WIN windows per channel. Only windows containing at least one sample above threshold contribute to that sum. It scales each sum to a CAV value and raises per-channel and combined alarms for the downstream alarm/telemetry logic.

## Interface
- CLK_DIV, 100000: i_clk cycles per sample tick (1 kHz at 100 MHz); must be ≥ 4
- N_CH, 3: channel count
- DATA_W, 24: unsigned sample width
- SAMPLES_PER_WIN, 1000: samples per window
- N_WIN, 16: windows in the sliding sum; ≥ 2
- WIN_THRESHOLD, 24'h006666: window-valid level (DATA_W bits)
- TS_W, 20: TIMESCALE width
- TIMESCALE, 20'h00419: scale factor (dt in fixed point)
- CAV_THRESHOLD, 58'h0001_0000000000: alarm level (CAV_W bits)
- Derived widths:
  - ACC_W = DATA_W + $clog2(SAMPLES_PER_WIN)
  - SUM_W = ACC_W + $clog2(N_WIN)
  - CAV_W = SUM_W + TS_W
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_data  in  N_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]; sampled only on tick cycles
- i_accept  in  1  operator acknowledge; used only when WBCAV_LATCH_EN is defined
- o_win_done  out  1  one-cycle pulse when o_cav/o_alarm_ch update
- o_cav  out  N_CH*CAV_W  latest per-channel CAV (sum × TIMESCALE)
- o_alarm_ch  out  N_CH  per-channel alarm
- o_alarm  out  1  OR of o_alarm_ch

## Operation
- Tick divider:
  - Counter runs 0..CLK_DIV-1.
  - tick is high on the cycle the counter equals CLK_DIV-1.
- Per channel, on each tick: acc += sample; valid |= (sample > WIN_THRESHOLD). The comparison is strict.
- Sample counter runs 0..SAMPLES_PER_WIN-1.
- The closing tick is the tick at count SAMPLES_PER_WIN-1. It includes its own sample, so each window holds exactly SAMPLES_PER_WIN samples.
- On the closing tick:
  - Window value W = (valid incl. current sample) ? acc+sample : 0.
  - acc, valid and the sample counter clear, so the next tick starts the new window.
- Ring buffer: N_WIN × SUM-sized entries per channel, one write pointer shared by all channels, wrapping N_WIN-1 → 0.
- Running sum: sum ← sum + W − ring[ptr]; ring[ptr] ← W; ptr advances. No adder tree.
- FSM states:
  - ACCUM → UPDATE on the closing tick.
  - UPDATE: ring write and sum update. → MULT.
  - MULT: cav ← sum × TIMESCALE (registered). → CMP.
  - CMP: compare, drive outputs. → ACCUM.
- Accumulation continues in every state; CLK_DIV ≥ 4 guarantees no tick overlaps UPDATE..CMP.
- Compare: hit_c = cav_c > CAV_THRESHOLD (strict).
- All arithmetic is unsigned and sized by the derived widths, so no overflow or wrap is possible.
- Reset (any time, including mid-window):
  - Clears divider, sample counter, acc, valid, ring, sums, ptr and all outputs.
  - FSM returns to ACCUM.
  - The partial window is discarded.

## Timing
- Closing tick at cycle T:
  - T+1: ring and sums updated.
  - T+2: cav registered.
  - T+3: o_cav, o_alarm_ch and o_alarm update, and o_win_done pulses for one cycle.
- All outputs are registered. Reset values: o_win_done=0, o_cav=0, o_alarm_ch=0, o_alarm=0.
- The first non-zero o_cav is possible after the first full window following reset.
- The window period is SAMPLES_PER_WIN × CLK_DIV cycles, with no drift. Tick phase is unaffected by FSM activity.

## Configuration
- WBCAV_LATCH_EN undefined (non-latching):
  - o_alarm_ch[c] ← hit_c on every o_win_done cycle.
  - i_accept is ignored.
- WBCAV_LATCH_EN defined (latching):
  - o_alarm_ch[c] is sticky: set when hit_c in CMP.
  - Cleared by i_accept=1 on any cycle.
  - If set and accept coincide in the same CMP cycle, set wins.

## Test plan
Test parameters: N_CH=3, SAMPLES_PER_WIN=4, N_WIN=4, CLK_DIV=8, TIMESCALE=1, TS_W=20, WIN_THRESHOLD=10, CAV_THRESHOLD=100.

- **Reset mid-window.** Drive i_rst_n low after 2 ticks with ch0=50. → All outputs are 0. After release, o_win_done pulses first at closing tick + 3, i.e. 4 full ticks later, with o_cav ch0=200.
- **Threshold boundary.**
  - All channels held at 10 (equal to threshold) for one window → o_cav=0 and no alarm.
  - Same with 11 → o_cav=44 per channel and no alarm.
- **Single-channel hit.** ch1 = 30,30,30,30, others 0. → At T+3, o_cav ch1=120, o_alarm_ch=3'b010, o_alarm=1 and o_win_done=1 for one cycle.
- **Expiry (non-latching).** After the hit, feed 4 all-zero windows. → ch1 o_cav reads 120,120,120,0. o_alarm_ch drops to 0 at the 4th done.
- **Latching (WBCAV_LATCH_EN).**
  - Repeat the expiry test → alarm stays 1 after o_cav=0.
  - i_accept pulse → 0 next cycle.
  - i_accept asserted during the CMP cycle of a hit → stays 1.
- **Ring wrap.** WIN_THRESHOLD=0; ch2 windows totalling 10,20,30,40,50,60 (single non-zero sample each). → o_cav ch2 = 10,30,60,100,140,180. o_alarm_ch[2] is first 1 at the 140 window.
